// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared DMAC constants and FSM state encoding
//
// Purpose: default widths shared by the channel FIFO, the source engine and
//          the destination write engine, plus the engine state encoding.
// Ports:   none (package).
package dmac_pkg;

  localparam int DMAC_DATA_W = 16;
  localparam int DMAC_ADDR_W = 16;
  localparam int DMAC_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dmac_state_e;

endpackage

// File: rtl/dma_write_engine_if.sv
// rtl/dma_write_engine_if.sv - FIFO-drain and memory-write bus of the write engine
//
// Purpose: bundles the FIFO read side and the single-beat memory write
//          handshake seen by dma_write_engine.
// Ports (master = engine side):
//   fifo_empty in, fifo_dout in, fifo_rd_en out,
//   mem_wr_en out, mem_addr out, mem_wdata out, mem_ack in.
interface dma_write_engine_if
  import dmac_pkg::*;
#(
  parameter int DATA_W = DMAC_DATA_W,
  parameter int ADDR_W = DMAC_ADDR_W
) ();

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    input  fifo_empty, fifo_dout, mem_ack,
    output fifo_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    output fifo_empty, fifo_dout, mem_ack,
    input  fifo_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmac_xfer_cnt.sv
// rtl/dmac_xfer_cnt.sv - transfer address up-counter and remaining-word down-counter
//
// Purpose: holds the current transfer address and the number of words still
//          to move; shared by the source and destination engines.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       take load_addr/load_len (has priority over step)
//   step       one word completed: addr+1 (wraps), remain-1
//   load_addr  first address
//   load_len   word count
//   addr       current address
//   last       remain == 1
module dmac_xfer_cnt
  import dmac_pkg::*;
#(
  parameter int ADDR_W = DMAC_ADDR_W,
  parameter int LEN_W  = DMAC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (load) begin
      addr_q   <= load_addr;
      remain_q <= load_len;
    end else if (step) begin
      // Address wraps naturally at 2^ADDR_W; callers never step at remain 0.
      addr_q   <= addr_q + 1'b1;
      remain_q <= remain_q - 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (remain_q == LEN_W'(1));

endmodule

// File: rtl/dma_write_engine.sv
// rtl/dma_write_engine.sv - DMAC destination engine: drains the FIFO into memory
//
// Purpose: on start, pops xfer_len words from the channel FIFO one at a time
//          and writes each to memory at an incrementing address using a
//          single-beat wr_en/ack handshake; pulses done when finished.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      one-cycle request (IDLE only) / cancel transfer
//   dst_addr          first destination address (latched on start)
//   xfer_len          word count (latched on start)
//   busy, done        not-IDLE indication / one-cycle completion pulse
//   bus (master)      FIFO read side and memory write handshake
module dma_write_engine
  import dmac_pkg::*;
#(
  parameter int DATA_W = DMAC_DATA_W,
  parameter int ADDR_W = DMAC_ADDR_W,
  parameter int LEN_W  = DMAC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              busy,
  output logic              done,
  dma_write_engine_if.master bus
);

  dmac_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;
  logic              rd_en;
  logic              cnt_load;
  logic              cnt_step;

  // Pop only while fetching and the FIFO has data; this is the one output
  // that depends combinationally on an input.
  assign rd_en    = (state_q == ST_FETCH) && !bus.fifo_empty;
  assign cnt_load = (state_q == ST_IDLE) && start && !abort && (xfer_len != '0);
  // abort overrides a same-cycle ack, so the address/count do not advance.
  assign cnt_step = (state_q == ST_WRITE) && bus.mem_ack && !abort;

  dmac_xfer_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .step      (cnt_step),
    .load_addr (dst_addr),
    .load_len  (xfer_len),
    .addr      (cnt_addr),
    .last      (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_en) begin
      data_q <= bus.fifo_dout;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = (xfer_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rd_en) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus.mem_ack) begin
          state_d = cnt_last ? ST_DONE : ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.fifo_rd_en = rd_en;
    bus.mem_wr_en  = (state_q == ST_WRITE);
    bus.mem_addr   = cnt_addr;
    bus.mem_wdata  = data_q;
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_dma_write_engine.sv
// tb/tb_dma_write_engine.sv - self-checking bench for dma_write_engine
module tb_dma_write_engine;
  import dmac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] dst_addr;
  logic [7:0]  xfer_len;
  logic        busy;
  logic        done;

  dma_write_engine_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  dma_write_engine #(.DATA_W(16), .ADDR_W(16), .LEN_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .dst_addr (dst_addr),
    .xfer_len (xfer_len),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] fq[$];
  logic [31:0] sb[$];
  int ncmp, nfail, cyc, pops, writes, dones, done_cyc, hold_cnt;
  int stall_word, stall_left, s;
  bit chk_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dout  = (fq.size() != 0) ? fq[0] : 16'h0000;
  endtask

  // One clock: sample at the falling edge, then step the FIFO model after the rising edge.
  task automatic cycle();
    logic rd;
    logic [31:0] e;
    @(negedge clk);
    if (bus.mem_wr_en && writes == stall_word && stall_left > 0) begin
      bus.mem_ack = 1'b0;
      stall_left--;
    end else begin
      bus.mem_ack = 1'b1;
    end
    #1;
    if (chk_empty && bus.fifo_empty) chk("rd_while_empty", {31'd0, bus.fifo_rd_en}, 32'd0);
    if (bus.fifo_rd_en) pops++;
    if (bus.mem_wr_en && bus.mem_addr == 16'h0101 && bus.mem_wdata == 16'h0022) hold_cnt++;
    if (bus.mem_wr_en && bus.mem_ack && !abort) begin
      writes++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {16'd0, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {16'd0, bus.mem_addr}, {16'd0, e[31:16]});
        chk("wr_data", {16'd0, bus.mem_wdata}, {16'd0, e[15:0]});
      end
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    rd = bus.fifo_rd_en;
    @(posedge clk);
    cyc++;
    if (rd && fq.size() != 0) void'(fq.pop_front());
    #1 fifo_drive();
  endtask

  task automatic run_until_done(input int maxc);
    int d0;
    d0 = dones;
    for (int i = 0; i < maxc && dones == d0; i++) cycle();
    chk("done_count", dones - d0, 32'd1);
  endtask

  task automatic clear_counts();
    pops = 0; writes = 0; dones = 0; hold_cnt = 0; stall_word = -1; stall_left = 0;
  endtask

  task automatic do_start(input logic [15:0] a, input logic [7:0] l);
    start = 1'b1; dst_addr = a; xfer_len = l;
    s = cyc;
    cycle();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, bus.fifo_rd_en}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, bus.mem_wr_en}, 32'd0);
    chk({tag, "_addr"},  {16'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ncmp = 0; nfail = 0; cyc = 0; chk_empty = 0;
    clear_counts();
    rst = 1'b1; start = 1'b0; abort = 1'b0; dst_addr = '0; xfer_len = '0;
    bus.mem_ack = 1'b1;
    fifo_drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic transfer
    clear_counts();
    fq = '{16'h0012, 16'h0022, 16'h0032}; fifo_drive();
    sb = '{32'h0100_0012, 32'h0101_0022, 32'h0102_0032};
    do_start(16'h0100, 8'd3);
    chk("basic_busy_after_start", {31'd0, busy}, 32'd1);
    run_until_done(30);
    chk("basic_done_latency", done_cyc - s, 32'd7);
    repeat (3) cycle();
    chk("basic_pops", pops, 32'd3);
    chk("basic_done_once", dones, 32'd1);
    chk("basic_sb_empty", sb.size(), 32'd0);
    chk("basic_idle", {31'd0, busy}, 32'd0);

    // Ack stall on the second word
    clear_counts();
    stall_word = 1; stall_left = 3;
    fq = '{16'h0012, 16'h0022, 16'h0032}; fifo_drive();
    sb = '{32'h0100_0012, 32'h0101_0022, 32'h0102_0032};
    do_start(16'h0100, 8'd3);
    run_until_done(40);
    chk("stall_hold_cycles", hold_cnt, 32'd4);
    chk("stall_pops", pops, 32'd3);
    chk("stall_sb_empty", sb.size(), 32'd0);
    chk("stall_latency", done_cyc - s, 32'd10);

    // Empty FIFO
    clear_counts();
    chk_empty = 1;
    sb = '{32'h0040_00AA, 32'h0041_00BB};
    do_start(16'h0040, 8'd2);
    repeat (5) cycle();
    chk("empty_no_pop", pops, 32'd0);
    chk("empty_no_write", writes, 32'd0);
    chk("empty_busy", {31'd0, busy}, 32'd1);
    fq.push_back(16'h00AA); fifo_drive();
    repeat (6) cycle();
    chk("empty_one_write", writes, 32'd1);
    chk("empty_one_pop", pops, 32'd1);
    chk("empty_no_done_yet", dones, 32'd0);
    fq.push_back(16'h00BB); fifo_drive();
    run_until_done(20);
    chk("empty_two_writes", writes, 32'd2);
    chk("empty_sb_empty", sb.size(), 32'd0);
    chk_empty = 0;
    cycle();

    // Address wrap
    clear_counts();
    fq = '{16'h1111, 16'h2222}; fifo_drive();
    sb = '{32'hFFFF_1111, 32'h0000_2222};
    do_start(16'hFFFF, 8'd2);
    run_until_done(20);
    chk("wrap_sb_empty", sb.size(), 32'd0);
    cycle();

    // Zero length
    clear_counts();
    do_start(16'h0777, 8'd0);
    run_until_done(5);
    chk("zero_done_latency", done_cyc - s, 32'd1);
    chk("zero_pops", pops, 32'd0);
    chk("zero_writes", writes, 32'd0);
    cycle();

    // Abort in WRITE of word 2 together with ack
    clear_counts();
    fq = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4}; fifo_drive();
    sb = '{32'h0300_00A1};
    do_start(16'h0300, 8'd4);
    for (int i = 0; i < 20; i++) begin
      if (writes == 1 && bus.mem_wr_en) break;
      cycle();
    end
    chk("abort_in_write2", {31'd0, bus.mem_wr_en}, 32'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_idle_next", {31'd0, busy}, 32'd0);
    chk("abort_addr_held", {16'd0, bus.mem_addr}, 32'h0000_0301);
    repeat (4) cycle();
    chk("abort_no_done", dones, 32'd0);
    chk("abort_pops", pops, 32'd2);
    chk("abort_writes", writes, 32'd1);
    chk("abort_sb_empty", sb.size(), 32'd0);
    fq.delete(); fifo_drive();

    // Reset mid-transfer
    clear_counts();
    fq = '{16'h0055, 16'h0066}; fifo_drive();
    sb = '{32'h0500_0055, 32'h0501_0066};
    do_start(16'h0500, 8'd3);
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", dones, 32'd0);
    fq.delete(); sb.delete(); fifo_drive();

    // Start while busy is ignored
    clear_counts();
    sb = '{32'h0200_0C01, 32'h0201_0C02};
    do_start(16'h0200, 8'd2);
    start = 1'b1; dst_addr = 16'h0300; xfer_len = 8'd5;
    cycle();
    start = 1'b0;
    fq = '{16'h0C01, 16'h0C02}; fifo_drive();
    run_until_done(20);
    chk("busy_start_writes", writes, 32'd2);
    chk("busy_start_sb_empty", sb.size(), 32'd0);
    cycle();
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/dma_write_engine.md
# dma_write_engine

Destination-side transfer engine of the DMAC, directly downstream of the channel's 16-bit × 8-deep FIFO. On a start command it pops words from the FIFO one at a time and writes each to destination memory at an incrementing address. It runs a single-beat write handshake per word and signals completion with a one-cycle `done` pulse. The source-side engine fills the FIFO concurrently; this block only drains it.

## Interface
Parameters:
- `DATA_W`, 16, word width; must match the FIFO width.
- `ADDR_W`, 16, destination address width.
- `LEN_W`, 8, width of the transfer word count.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled in IDLE only.
- `abort`  in  1  cancels the transfer in progress.
- `dst_addr`  in  ADDR_W  first destination address; latched on accepted `start`.
- `xfer_len`  in  LEN_W  number of words to move; latched on accepted `start`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_W  FIFO read data; valid in the same cycle as `fifo_rd_en` while not empty.
- `fifo_rd_en`  out  1  FIFO pop request.
- `mem_wr_en`  out  1  write request; held high until `mem_ack`.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_ack`  in  1  memory accepted the write this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - `start` with `xfer_len`≠0: latch address into `addr_q` and count into `remain_q`, then go to FETCH.
  - `start` with `xfer_len`=0: go to DONE; no FIFO reads, no writes.
- FETCH:
  - `fifo_rd_en` = (state==FETCH) && !`fifo_empty`. This is combinational; the engine never pops an empty FIFO.
  - On an edge with `fifo_rd_en`=1: capture `fifo_dout` into `data_q` and go to WRITE.
  - If the FIFO is empty, stay in FETCH indefinitely. There is no timeout.
- WRITE:
  - `mem_wr_en`=1, `mem_addr`=`addr_q`, `mem_wdata`=`data_q`. All three are stable until ack.
  - On `mem_ack`: `addr_q`+1, wrapping modulo 2^ADDR_W; `remain_q`−1.
  - After the ack, go to DONE if `remain_q` was 1, otherwise to FETCH.
  - `mem_ack` is ignored outside WRITE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. `dst_addr` and `xfer_len` are don't-care outside an accepted start.
- `abort`:
  - In FETCH, WRITE or DONE: go to IDLE on the next edge. No `done` pulse; any word held in `data_q` is discarded.
  - A word already popped is lost, and the FIFO is not rewound.
  - `abort` overrides `mem_ack` in the same cycle: the address and count do not advance.
  - In IDLE, `abort` wins over `start`; the start is dropped.
- Arithmetic:
  - `remain_q` is LEN_W bits and never underflows, because the 0 case is handled in IDLE.
  - Maximum transfer is 2^LEN_W−1 words.

## Timing
- Reset values: state IDLE; `fifo_rd_en`, `mem_wr_en`, `busy`, `done` = 0; `mem_addr`, `mem_wdata`, `addr_q`, `remain_q` = 0.
- `rst` asserted mid-transfer returns the block to IDLE immediately (asynchronous), with no `done`.
- Latency, with `start` sampled at edge N:
  - `busy` high from N.
  - First `fifo_rd_en` in the cycle after N, if the FIFO is non-empty.
  - `mem_wr_en` high from the next edge.
- Throughput: best case one word per 2 cycles (FETCH cycle plus WRITE with immediate ack). Each FIFO-empty cycle or ack wait adds one cycle.
- `done` is high in the cycle after the final ack; `busy` is high in that same cycle.
- All outputs other than `fifo_rd_en` are registered or decoded from state and registers only. None depends combinationally on `mem_ack`.

## Structure
- Shared `dmac_pkg`: state encoding (IDLE=0, FETCH=1, WRITE=2, DONE=3), plus default `DATA_W`/`ADDR_W`/`LEN_W` constants shared with the FIFO and the source engine.
- One sub-module, `dmac_xfer_cnt`: address up-counter plus remaining down-counter.
  - Inputs: `load`, `step`.
  - Outputs: `addr`, `last` (remain==1).
  - The source engine reuses the same sub-module.
- The FSM and the data register stay in the top module.

## Test plan
- **Basic transfer.** FIFO preloaded with 0x0012, 0x0022, 0x0032; start with `dst_addr`=0x0100, `xfer_len`=3; `mem_ack` tied high.
  - Required: writes (0x0100,0x0012), (0x0101,0x0022), (0x0102,0x0032).
  - Exactly 3 pops; `done` pulses once, 7 cycles after start.
- **Ack stall.** As above, but `mem_ack` is delayed 3 cycles on the 2nd word.
  - Required: `mem_wr_en`/`mem_addr`/`mem_wdata` hold 0x0101/0x0022 steady for 4 cycles; no extra pop occurs.
- **Empty FIFO.** Start `xfer_len`=2 with the FIFO empty, then push 0x00AA after 5 cycles and 0x00BB later.
  - Required: `fifo_rd_en` stays 0 while empty.
  - Writes occur only after each push; `done` follows the 2nd ack.
- **Wrap and zero length.**
  - `dst_addr`=0xFFFF, `xfer_len`=2: required writes go to 0xFFFF then 0x0000.
  - `xfer_len`=0: required `done` in the cycle after start, with zero pops and zero writes.
- **Abort and reset.**
  - `abort` in WRITE of word 2 of 4, in the same cycle as `mem_ack`: required IDLE next cycle, no `done`, exactly 2 pops.
  - `rst` mid-transfer: required all outputs 0 immediately.
- **Start while busy.** Second `start` during FETCH with different `dst_addr`: required it is ignored and the addresses continue from the first transfer.
